// File: rtl/ddr5_pkg.sv
// Shared DDR5 read-path definitions: burst geometry defaults and the capture
// FSM encoding, so the read-latency shift register and the capture stage agree.
package ddr5_pkg;

    localparam int DDR5_DQ_W      = 8;
    localparam int DDR5_BURST_LEN = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } rd_state_e;

endpackage

// File: rtl/rd_out_fifo.sv
// Two-entry output buffer for assembled read words. The head is presented
// whenever the buffer is non-empty. A push into a full buffer is accepted only
// when a pop happens in the same cycle.
module rd_out_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_ok, push_ok;

    assign full  = (cnt_q == 2'd2);
    assign valid = (cnt_q != 2'd0);
    // Drive zero when empty so a flushed buffer never shows a stale word.
    assign head  = valid ? mem_q[rd_ptr_q] : '0;

    // Next-state: when full, pop frees the head slot, which is also the write slot.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        pop_ok   = pop && valid;
        push_ok  = push && (!full || pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointers, flushed by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/rd_burst_capture.sv
// Read burst capture: starting on the delayed read-enable pulse, gathers
// BURST_LEN DQ beats into one word, queues it in a 2-entry buffer, and keeps
// sticky overflow / protocol error flags.
module rd_burst_capture
    import ddr5_pkg::*;
#(
    parameter int DQ_W      = DDR5_DQ_W,
    parameter int BURST_LEN = DDR5_BURST_LEN
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_start,
    input  logic [DQ_W-1:0]           dq_in,
    output logic [DQ_W*BURST_LEN-1:0] rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      busy,
    output logic                      ovf,
    output logic                      proto_err,
    input  logic                      clr_err
);

    localparam int               CNT_W  = $clog2(BURST_LEN);
    localparam int               WORD_W = DQ_W * BURST_LEN;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(BURST_LEN - 1);

    rd_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic              ovf_q, ovf_d;
    logic              perr_q, perr_d;
    logic              push, perr_set, ovf_set;
    logic              fifo_full, pop;

    assign pop       = rd_valid && rd_ready;
    assign busy      = (state_q == CAPTURE);
    assign ovf       = ovf_q;
    assign proto_err = perr_q;

    // Capture FSM: the last beat is merged into asm_d so the pushed word is complete.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        push     = 1'b0;
        perr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_start) begin
                    asm_d[DQ_W-1:0] = dq_in;
                    cnt_d           = CNT_W'(1);
                    state_d         = CAPTURE;
                end
            end
            CAPTURE: begin
                asm_d[cnt_q*DQ_W +: DQ_W] = dq_in;
                perr_set                  = rd_start;
                if (cnt_q == LAST) begin
                    push    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: a set event beats a simultaneous clear.
    always_comb begin
        ovf_set = push && fifo_full && !pop;
        ovf_d   = ovf_set  ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        perr_d  = perr_set ? 1'b1 : (clr_err ? 1'b0 : perr_q);
    end

    // Capture state, beat counter, assembly register and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end

    rd_out_fifo #(.WIDTH(WORD_W)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (asm_d),
        .full      (fifo_full),
        .pop       (pop),
        .valid     (rd_valid),
        .head      (rd_data)
    );

endmodule

// File: tb/tb_rd_burst_capture.sv
// Bench for rd_burst_capture: directed scenarios plus random traffic on a
// DQ_W=8/BURST_LEN=4 instance, and a short run on a default-parameter instance.
module tb_rd_burst_capture;

    localparam int BL  = 4;
    localparam int BL2 = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_start, rd_ready, clr_err;
    logic [7:0]    dq_in;
    logic [31:0]   rd_data;
    logic          rd_valid, busy, ovf, proto_err;

    logic          rd_start2, rd_ready2, clr_err2;
    logic [7:0]    dq2;
    logic [127:0]  rd_data2;
    logic          rd_valid2, busy2, ovf2, perr2;

    int            checks = 0;
    int            failures = 0;
    bit            mon_en = 1'b0;

    // behavioural model: beats of the burst in flight, buffered word count, flags
    logic [7:0]    cur[$];
    logic [31:0]   sb[$];
    int            mcount = 0;
    bit            ovf_exp = 1'b0;
    bit            perr_exp = 1'b0;
    int            popped = 0;
    logic [127:0]  sb2[$];
    int            got2 = 0;

    always #5 clk = ~clk;

    rd_burst_capture #(.DQ_W(8), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst), .rd_start(rd_start), .dq_in(dq_in),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .ovf(ovf), .proto_err(proto_err), .clr_err(clr_err)
    );

    rd_burst_capture dut_def (
        .clk(clk), .rst(rst), .rd_start(rd_start2), .dq_in(dq2),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .rd_ready(rd_ready2),
        .busy(busy2), .ovf(ovf2), .proto_err(perr2), .clr_err(clr_err2)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock of the reference model, using the inputs that the DUT sampled.
    task automatic model_update();
        bit          pop_m;
        bit          done;
        bit          ovf_set;
        bit          perr_set;
        logic [31:0] w;
        pop_m    = rd_ready && (mcount > 0);
        done     = 1'b0;
        ovf_set  = 1'b0;
        perr_set = 1'b0;
        w        = '0;
        if (cur.size() > 0) begin
            cur.push_back(dq_in);
            if (rd_start) perr_set = 1'b1;
        end else if (rd_start) begin
            cur.push_back(dq_in);
        end
        if (cur.size() == BL) begin
            for (int k = 0; k < BL; k++) w[k*8 +: 8] = cur[k];
            cur.delete();
            done = 1'b1;
        end
        if (pop_m) mcount--;
        if (done) begin
            if (mcount < 2) begin
                mcount++;
                sb.push_back(w);
            end else begin
                ovf_set = 1'b1;
            end
        end
        ovf_exp  = ovf_set  ? 1'b1 : (clr_err ? 1'b0 : ovf_exp);
        perr_exp = perr_set ? 1'b1 : (clr_err ? 1'b0 : perr_exp);
    endtask

    task automatic step(input bit st, input logic [7:0] d, input bit rdy, input bit clr);
        rd_start = st;
        dq_in    = d;
        rd_ready = rdy;
        clr_err  = clr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic burst(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input bit rdy);
        step(1'b1, b0, rdy, 1'b0);
        step(1'b0, b1, rdy, 1'b0);
        step(1'b0, b2, rdy, 1'b0);
        step(1'b0, b3, rdy, 1'b0);
    endtask

    task automatic step2(input bit st, input logic [7:0] d);
        rd_start  = 1'b0;
        rd_ready  = 1'b1;
        clr_err   = 1'b0;
        rd_start2 = st;
        dq2       = d;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Monitor for the BURST_LEN=4 instance: outputs vs. model state each cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && mon_en) begin
            chk("rd_valid", rd_valid, mcount > 0);
            chk("busy", busy, cur.size() > 0);
            chk("ovf", ovf, ovf_exp);
            chk("proto_err", proto_err, perr_exp);
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h required=none", rd_data);
                end else begin
                    chk("rd_data", rd_data, sb.pop_front());
                    popped++;
                end
            end
        end
    end

    // Monitor for the default-parameter instance.
    always @(negedge clk) begin
        if (rst === 1'b1 && mon_en && rd_valid2) begin
            if (sb2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d2_unexpected_word actual=%0h required=none", rd_data2);
            end else begin
                chk("d2_rd_data", rd_data2, sb2.pop_front());
            end
            got2++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        logic [127:0] w2;
        rst = 1'b0; rd_start = 0; rd_ready = 0; clr_err = 0; dq_in = 0;
        rd_start2 = 0; rd_ready2 = 1; clr_err2 = 0; dq2 = 0;
        #12;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b1;
        mon_en = 1'b1;

        // single burst
        burst(8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
        chk("t1_data", rd_data, 32'h44332211);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // back-to-back bursts
        burst(8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        chk("t2_word0", rd_data, 32'h04030201);
        burst(8'h05, 8'h06, 8'h07, 8'h08, 1'b1);
        chk("t2_word1", rd_data, 32'h08070605);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // backpressure and overflow
        burst(8'ha1, 8'ha2, 8'ha3, 8'ha4, 1'b0);
        burst(8'hb1, 8'hb2, 8'hb3, 8'hb4, 1'b0);
        burst(8'hc1, 8'hc2, 8'hc3, 8'hc4, 1'b0);
        chk("t3_head_held", rd_data, 32'ha4a3a2a1);
        chk("t3_ovf", ovf, 1);
        p0 = popped;
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t3_drain", popped - p0, 2);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // mid-burst rd_start
        step(1'b1, 8'h31, 1'b1, 1'b0);
        step(1'b0, 8'h32, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b0, 8'h34, 1'b1, 1'b0);
        chk("t4_data", rd_data, 32'h34333231);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_proto_err", proto_err, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // full buffer, pop and push on the last beat
        burst(8'h51, 8'h52, 8'h53, 8'h54, 1'b0);
        burst(8'h61, 8'h62, 8'h63, 8'h64, 1'b0);
        step(1'b1, 8'h71, 1'b0, 1'b0);
        step(1'b0, 8'h72, 1'b0, 1'b0);
        step(1'b0, 8'h73, 1'b0, 1'b0);
        step(1'b0, 8'h74, 1'b1, 1'b0);
        chk("t5_ovf", ovf, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // async reset mid-burst, with a word buffered and proto_err set
        burst(8'h81, 8'h82, 8'h83, 8'h84, 1'b0);
        step(1'b1, 8'h91, 1'b0, 1'b0);
        step(1'b1, 8'h92, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_proto_err", proto_err, 0);
        chk("t6_rd_data", rd_data, 0);
        cur.delete(); sb.delete(); mcount = 0; ovf_exp = 0; perr_exp = 0;
        #3;
        rst = 1'b1;
        burst(8'haa, 8'hbb, 8'hcc, 8'hdd, 1'b1);
        chk("t6_fresh", rd_data, 32'hddccbbaa);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom % 4) == 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 16) == 0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("rand_sb_empty", sb.size(), 0);

        // default-parameter instance: three back-to-back bursts
        for (int b = 0; b < 3; b++) begin
            w2 = '0;
            for (int k = 0; k < BL2; k++) begin
                logic [7:0] d;
                d = 8'($urandom);
                w2[k*8 +: 8] = d;
                step2(k == 0, d);
            end
            sb2.push_back(w2);
        end
        for (int i = 0; i < 4; i++) step2(1'b0, 8'h00);
        chk("d2_words", got2, 3);
        chk("d2_ovf", ovf2, 0);
        chk("d2_proto_err", perr2, 0);
        chk("d2_busy", busy2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
